// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters.
// One operation in flight; valid/ready on request and response sides.
module alu_arbiter #(
    parameter int MUL_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req0_fsl,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [3:0] req1_fsl,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic [3:0] alu_fsl,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    input  logic [7:0] alu_mul_high,
    input  logic [3:0] alu_sreg,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_id,
    output logic [7:0] resp_result,
    output logic [7:0] resp_mul_high,
    output logic [3:0] resp_sreg,
    output logic [3:0] sreg_ctx0,
    output logic [3:0] sreg_ctx1
);

    localparam logic [3:0] OPC_MUL = 4'b1110;
    localparam logic [3:0] MUL_CNT = 4'(MUL_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [3:0] cnt_q, cnt_d;
    logic       id_q, id_d;
    logic [3:0] fsl_q, fsl_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] res_q, res_d;
    logic [7:0] mh_q, mh_d;
    logic [3:0] sreg_q, sreg_d;
    logic [3:0] ctx0_q, ctx0_d;
    logic [3:0] ctx1_q, ctx1_d;

    logic       grant;
    logic       accept;
    logic [3:0] sel_fsl;
    logic [7:0] sel_a;
    logic [7:0] sel_b;

    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_q;
            default: grant = 1'b0;
        endcase
    end

    // Ready only goes to the granted requester, so valid&ready == accept.
    assign accept    = (state_q == IDLE) && (|req_valid);
    assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

    assign sel_fsl = grant ? req1_fsl : req0_fsl;
    assign sel_a   = grant ? req1_a   : req0_a;
    assign sel_b   = grant ? req1_b   : req0_b;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        fsl_d        = fsl_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        mh_d         = mh_q;
        sreg_d       = sreg_q;
        ctx0_d       = ctx0_q;
        ctx1_d       = ctx1_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    fsl_d   = sel_fsl;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    id_d    = grant;
                    cnt_d   = (sel_fsl == OPC_MUL) ? MUL_CNT : 4'd0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_d        = alu_result;
                    mh_d         = alu_mul_high;
                    sreg_d       = alu_sreg;
                    last_grant_d = id_q;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    if (id_q) ctx1_d = sreg_q;
                    else      ctx0_d = sreg_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            id_q         <= 1'b0;
            fsl_q        <= 4'd0;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            res_q        <= 8'd0;
            mh_q         <= 8'd0;
            sreg_q       <= 4'd0;
            ctx0_q       <= 4'd0;
            ctx1_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            fsl_q        <= fsl_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            mh_q         <= mh_d;
            sreg_q       <= sreg_d;
            ctx0_q       <= ctx0_d;
            ctx1_q       <= ctx1_d;
        end
    end

    assign alu_fsl       = fsl_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign resp_valid    = (state_q == RESP);
    assign resp_id       = id_q;
    assign resp_result   = res_q;
    assign resp_mul_high = mh_q;
    assign resp_sreg     = sreg_q;
    assign sreg_ctx0     = ctx0_q;
    assign sreg_ctx1     = ctx1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small stand-in ALU.
// SREG is {V,S,C,Z}; S here is the result sign bit.
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req0_fsl, req1_fsl;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] alu_fsl;
    logic [7:0] alu_a, alu_b;
    logic [7:0] alu_result, alu_mul_high;
    logic [3:0] alu_sreg;
    logic       resp_valid, resp_ready, resp_id;
    logic [7:0] resp_result, resp_mul_high;
    logic [3:0] resp_sreg, sreg_ctx0, sreg_ctx1;

    int n_chk;
    int n_err;

    alu_arbiter #(.MUL_WAIT(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req0_fsl     (req0_fsl),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_fsl     (req1_fsl),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .alu_fsl      (alu_fsl),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_mul_high (alu_mul_high),
        .alu_sreg     (alu_sreg),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_result  (resp_result),
        .resp_mul_high(resp_mul_high),
        .resp_sreg    (resp_sreg),
        .sreg_ctx0    (sreg_ctx0),
        .sreg_ctx1    (sreg_ctx1)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: 0=ADD, 1=SUB, 1110=MUL, others XOR.
    logic [8:0]  alu_sum;
    logic [15:0] alu_prod;
    logic        alu_v, alu_c;
    always_comb begin
        alu_sum      = 9'd0;
        alu_prod     = 16'd0;
        alu_v        = 1'b0;
        alu_c        = 1'b0;
        alu_result   = 8'd0;
        alu_mul_high = 8'd0;
        case (alu_fsl)
            4'd0: begin
                alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = alu_sum[7:0];
                alu_c      = alu_sum[8];
                alu_v      = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            4'd1: begin
                alu_sum    = {1'b0, alu_a} - {1'b0, alu_b};
                alu_result = alu_sum[7:0];
                alu_c      = alu_sum[8];
                alu_v      = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            4'b1110: begin
                alu_prod     = alu_a * alu_b;
                alu_result   = alu_prod[7:0];
                alu_mul_high = alu_prod[15:8];
                alu_c        = |alu_prod[15:8];
            end
            default: alu_result = alu_a ^ alu_b;
        endcase
        alu_sreg = {alu_v, alu_result[7], alu_c, alu_result == 8'd0};
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int nresp;

    initial begin
        n_chk      = 0;
        n_err      = 0;
        clk        = 1'b0;
        rst_n      = 1'b0;
        resp_ready = 1'b1;
        req_valid  = 2'b11;
        req0_fsl   = 4'd0;
        req0_a     = 8'h7F;
        req0_b     = 8'h01;
        req1_fsl   = 4'b1110;
        req1_a     = 8'h10;
        req1_b     = 8'h10;
        tick();
        tick();
        chk("rst_resp_valid", 16'(resp_valid), 16'h0);
        chk("rst_alu_fsl", 16'(alu_fsl), 16'h0);
        chk("rst_alu_a", 16'(alu_a), 16'h0);
        chk("rst_alu_b", 16'(alu_b), 16'h0);
        chk("rst_resp_result", 16'(resp_result), 16'h0);
        chk("rst_ctx0", 16'(sreg_ctx0), 16'h0);
        chk("rst_ctx1", 16'(sreg_ctx1), 16'h0);
        chk("rst_req_ready", 16'(req_ready), 16'h1);
        rst_n = 1'b1;

        // ADD by requester 0, then MUL by requester 1
        tick();
        chk("t1_ready_exec", 16'(req_ready), 16'h0);
        chk("t2_alu_a", 16'(alu_a), 16'h7F);
        chk("t2_alu_b", 16'(alu_b), 16'h01);
        chk("t2_valid_early", 16'(resp_valid), 16'h0);
        req_valid = 2'b10;
        tick();
        chk("t2_valid", 16'(resp_valid), 16'h1);
        chk("t2_result", 16'(resp_result), 16'h80);
        chk("t2_sreg", 16'(resp_sreg), 16'hC);
        chk("t2_id", 16'(resp_id), 16'h0);
        tick();
        chk("t2_valid_drop", 16'(resp_valid), 16'h0);
        chk("t2_ctx0", 16'(sreg_ctx0), 16'hC);
        chk("t1_ready_req1", 16'(req_ready), 16'h2);
        tick();
        req_valid = 2'b00;
        chk("t3_alu_fsl", 16'(alu_fsl), 16'hE);
        chk("t3_wait1", 16'(resp_valid), 16'h0);
        tick();
        chk("t3_wait2", 16'(resp_valid), 16'h0);
        tick();
        chk("t3_wait3", 16'(resp_valid), 16'h0);
        tick();
        chk("t3_valid", 16'(resp_valid), 16'h1);
        chk("t3_result", 16'(resp_result), 16'h00);
        chk("t3_mul_high", 16'(resp_mul_high), 16'h01);
        chk("t3_sreg", 16'(resp_sreg), 16'h3);
        chk("t3_id", 16'(resp_id), 16'h1);
        chk("t3_ctx1_before", 16'(sreg_ctx1), 16'h0);
        tick();
        chk("t3_valid_drop", 16'(resp_valid), 16'h0);
        chk("t3_ctx1", 16'(sreg_ctx1), 16'h3);
        chk("t3_ctx0_kept", 16'(sreg_ctx0), 16'hC);

        // Both requesters valid continuously: strict alternation
        req0_fsl  = 4'd1;
        req0_a    = 8'h05;
        req0_b    = 8'h03;
        req1_fsl  = 4'd0;
        req1_a    = 8'h01;
        req1_b    = 8'h02;
        req_valid = 2'b11;
        nresp     = 0;
        for (int cyc = 0; cyc < 60 && nresp < 6; cyc++) begin
            tick();
            if (resp_valid) begin
                chk("t4_id", 16'(resp_id), 16'(nresp % 2));
                chk("t4_result", 16'(resp_result), (nresp % 2 == 0) ? 16'h02 : 16'h03);
                nresp++;
                if (nresp == 6) req_valid = 2'b00;
            end
        end
        chk("t4_count", 16'(nresp), 16'd6);
        tick();

        // Response backpressure
        resp_ready = 1'b0;
        req0_fsl   = 4'd0;
        req0_a     = 8'h80;
        req0_b     = 8'h80;
        req_valid  = 2'b01;
        tick();
        req_valid = 2'b11;
        req0_a    = 8'h55;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_valid", 16'(resp_valid), 16'h1);
            chk("t5_result", 16'(resp_result), 16'h00);
            chk("t5_sreg", 16'(resp_sreg), 16'hB);
            chk("t5_id", 16'(resp_id), 16'h0);
            chk("t5_req_ready", 16'(req_ready), 16'h0);
            chk("t5_alu_a", 16'(alu_a), 16'h80);
            chk("t5_alu_b", 16'(alu_b), 16'h80);
            tick();
        end
        resp_ready = 1'b1;
        req_valid  = 2'b00;
        tick();
        chk("t5_release", 16'(resp_valid), 16'h0);
        chk("t5_ctx0", 16'(sreg_ctx0), 16'hB);
        chk("t5_alu_a_hold", 16'(alu_a), 16'h80);
        chk("t5_idle_ready", 16'(req_ready), 16'h0);

        // Reset in the middle of a MULTIPLY
        req1_fsl  = 4'b1110;
        req1_a    = 8'h03;
        req1_b    = 8'h04;
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        rst_n = 1'b0;
        tick();
        chk("t6_valid", 16'(resp_valid), 16'h0);
        chk("t6_ctx0", 16'(sreg_ctx0), 16'h0);
        chk("t6_ctx1", 16'(sreg_ctx1), 16'h0);
        chk("t6_alu_fsl", 16'(alu_fsl), 16'h0);
        chk("t6_ready", 16'(req_ready), 16'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_resp", 16'(resp_valid), 16'h0);
        end
        req0_fsl  = 4'd0;
        req0_a    = 8'h02;
        req0_b    = 8'h03;
        req_valid = 2'b01;
        #1;
        chk("t6_ready_new", 16'(req_ready), 16'h1);
        tick();
        req_valid = 2'b00;
        tick();
        chk("t6_new_valid", 16'(resp_valid), 16'h1);
        chk("t6_new_result", 16'(resp_result), 16'h05);
        chk("t6_new_id", 16'(resp_id), 16'h0);
        tick();
        chk("t6_new_done", 16'(resp_valid), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
